hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the five-stage RV32I core. It generates the EX-stage operand forwarding selects and the per-stage `pipe_load_*` / `pipe_rst_*` controls. It also sequences multi-cycle load-use bubbles, cache-miss freezes and branch flushes, and keeps saturating performance counters for stall cycles and flushes. It sits beside the datapath and replaces ad-hoc stall logic in the top-level control.

---
 rtl/hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX operand forwarding, stage load/flush controls,
// load-use bubble / cache-miss freeze sequencing and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned LU_BUBBLES = 1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic [REG_AW-1:0]         mem_rd,
  input  logic [REG_AW-1:0]         wb_rd,
  input  logic                      ex_load_regfile,
  input  logic                      mem_load_regfile,
  input  logic                      wb_load_regfile,
  input  logic                      ex_is_load,
  input  logic                      mem_is_load,
  input  logic                      ex_br_taken,
  input  logic                      icache_read,
  input  logic                      icache_resp,
  input  logic                      mem_dcache_req,
  input  logic                      dcache_resp,
  input  logic                      cnt_clr,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      pipe_load_ifid,
  output logic                      pipe_load_idex,
  output logic                      pipe_load_exmem,
  output logic                      pipe_load_memwb,
  output logic                      pipe_rst_ifid,
  output logic                      pipe_rst_idex,
  output logic                      pipe_rst_exmem,
  output logic                      pipe_rst_memwb,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_BUBBLE = 2'd1;
  localparam logic [1:0] ST_FREEZE = 2'd2;
  localparam int unsigned BW = 2;

  logic [1:0]    state, state_nxt, ret_state, ret_nxt, eff_state;
  logic [BW-1:0] bub_cnt, bub_nxt;
  logic          freeze, lu, stall_cyc, flush_cyc;
  logic [3:0]    load_v, rst_v;

  always_comb begin
    fwd_sel = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (ex_rs[i*REG_AW +: REG_AW] != '0) begin
        if (mem_load_regfile && !mem_is_load && (mem_rd == ex_rs[i*REG_AW +: REG_AW]))
          fwd_sel[i*2 +: 2] = 2'b01;
        else if (wb_load_regfile && (wb_rd == ex_rs[i*REG_AW +: REG_AW]))
          fwd_sel[i*2 +: 2] = 2'b10;
      end
    end
    if (!rst)
      fwd_sel = '0;
  end

  assign freeze = (mem_dcache_req & ~dcache_resp) | (icache_read & ~icache_resp);

  always_comb begin
    lu = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (id_rs_used[i] && (id_rs[i*REG_AW +: REG_AW] == ex_rd))
        lu = 1'b1;
    end
    lu = lu & ex_is_load & ex_load_regfile & (ex_rd != '0);
  end

  // A released freeze resumes whatever state it interrupted, evaluated this same cycle.
  assign eff_state = (state == ST_FREEZE) ? ret_state : state;

  always_comb begin
    state_nxt = state;
    ret_nxt   = ret_state;
    bub_nxt   = bub_cnt;
    load_v    = 4'b1111;
    rst_v     = 4'b0000;
    stall_cyc = 1'b0;
    flush_cyc = 1'b0;
    if (freeze) begin
      load_v    = 4'b0000;
      state_nxt = ST_FREEZE;
      ret_nxt   = eff_state;
      stall_cyc = 1'b1;
    end else if (ex_br_taken) begin
      rst_v     = 4'b1100;
      bub_nxt   = '0;
      state_nxt = ST_RUN;
      flush_cyc = 1'b1;
    end else if (eff_state == ST_BUBBLE) begin
      load_v    = 4'b0111;
      rst_v     = 4'b0100;
      stall_cyc = 1'b1;
      bub_nxt   = (bub_cnt == '0) ? '0 : bub_cnt - BW'(1);
      state_nxt = (bub_cnt <= BW'(1)) ? ST_RUN : ST_BUBBLE;
    end else if (lu) begin
      load_v    = 4'b0111;
      rst_v     = 4'b0100;
      stall_cyc = 1'b1;
      bub_nxt   = BW'(LU_BUBBLES - 1);
      state_nxt = (LU_BUBBLES > 1) ? ST_BUBBLE : ST_RUN;
    end else begin
      state_nxt = ST_RUN;
    end
  end

  assign {pipe_load_ifid, pipe_load_idex, pipe_load_exmem, pipe_load_memwb} =
    rst ? load_v : 4'b0000;
  assign {pipe_rst_ifid, pipe_rst_idex, pipe_rst_exmem, pipe_rst_memwb} =
    rst ? rst_v : 4'b1111;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      ret_state <= ST_RUN;
      bub_cnt   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
      bub_cnt   <= bub_nxt;
      if (cnt_clr) begin
        stall_cnt <= '0;
        flush_cnt <= '0;
      end else begin
        if (stall_cyc && !(&stall_cnt))
          stall_cnt <= stall_cnt + CNT_W'(1);
        if (flush_cyc && !(&flush_cnt))
          flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (LU_BUBBLES=2, CNT_W=4) with hand-computed expectations.
module tb_hazard_ctrl;

  localparam int unsigned NUM_SRC = 2;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned CNT_W   = 4;

  // {load_ifid, load_idex, load_exmem, load_memwb, rst_ifid, rst_idex, rst_exmem, rst_memwb}
  localparam logic [7:0] C_RUN = 8'b1111_0000;
  localparam logic [7:0] C_BUB = 8'b0111_0100;
  localparam logic [7:0] C_FRZ = 8'b0000_0000;
  localparam logic [7:0] C_FLU = 8'b1111_1100;
  localparam logic [7:0] C_RST = 8'b0000_1111;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_SRC*REG_AW-1:0] id_rs, ex_rs;
  logic [NUM_SRC-1:0]        id_rs_used;
  logic [REG_AW-1:0]         ex_rd, mem_rd, wb_rd;
  logic ex_load_regfile, mem_load_regfile, wb_load_regfile;
  logic ex_is_load, mem_is_load, ex_br_taken;
  logic icache_read, icache_resp, mem_dcache_req, dcache_resp, cnt_clr;
  logic [NUM_SRC*2-1:0] fwd_sel;
  logic pipe_load_ifid, pipe_load_idex, pipe_load_exmem, pipe_load_memwb;
  logic pipe_rst_ifid, pipe_rst_idex, pipe_rst_exmem, pipe_rst_memwb;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [7:0] ctl;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  hazard_ctrl #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .LU_BUBBLES(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_used(id_rs_used), .ex_rs(ex_rs),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_load_regfile(ex_load_regfile), .mem_load_regfile(mem_load_regfile),
    .wb_load_regfile(wb_load_regfile), .ex_is_load(ex_is_load), .mem_is_load(mem_is_load),
    .ex_br_taken(ex_br_taken), .icache_read(icache_read), .icache_resp(icache_resp),
    .mem_dcache_req(mem_dcache_req), .dcache_resp(dcache_resp), .cnt_clr(cnt_clr),
    .fwd_sel(fwd_sel),
    .pipe_load_ifid(pipe_load_ifid), .pipe_load_idex(pipe_load_idex),
    .pipe_load_exmem(pipe_load_exmem), .pipe_load_memwb(pipe_load_memwb),
    .pipe_rst_ifid(pipe_rst_ifid), .pipe_rst_idex(pipe_rst_idex),
    .pipe_rst_exmem(pipe_rst_exmem), .pipe_rst_memwb(pipe_rst_memwb),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign ctl = {pipe_load_ifid, pipe_load_idex, pipe_load_exmem, pipe_load_memwb,
                pipe_rst_ifid, pipe_rst_idex, pipe_rst_exmem, pipe_rst_memwb};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = '0; ex_rs = '0; id_rs_used = '0;
    ex_rd = '0; mem_rd = '0; wb_rd = '0;
    ex_load_regfile = 1'b0; mem_load_regfile = 1'b0; wb_load_regfile = 1'b0;
    ex_is_load = 1'b0; mem_is_load = 1'b0; ex_br_taken = 1'b0;
    icache_read = 1'b0; icache_resp = 1'b0; mem_dcache_req = 1'b0; dcache_resp = 1'b0;
    cnt_clr = 1'b0;
  endtask

  // Load in EX writing x7, ID source 1 reads x7.
  task automatic set_lu();
    ex_is_load = 1'b1; ex_load_regfile = 1'b1; ex_rd = 5'd7;
    id_rs = {5'd7, 5'd0}; id_rs_used = 2'b10;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    #1;
    check("rst_ctl", 32'(ctl), 32'(C_RST));
    check("rst_fwd", 32'(fwd_sel), 0);
    check("rst_stall", 32'(stall_cnt), 0);
    check("rst_flush", 32'(flush_cnt), 0);
    tick();
    rst = 1'b1;
    #1;
    check("release_ctl", 32'(ctl), 32'(C_RUN));

    // Forwarding priority
    ex_rs = {5'd0, 5'd5};
    mem_rd = 5'd5; mem_load_regfile = 1'b1;
    wb_rd = 5'd5; wb_load_regfile = 1'b1;
    #1 check("fwd_mem_beats_wb", 32'(fwd_sel), 32'h1);
    mem_load_regfile = 1'b0;
    #1 check("fwd_wb", 32'(fwd_sel), 32'h2);
    mem_load_regfile = 1'b1; mem_is_load = 1'b1;
    #1 check("fwd_mem_load_skip", 32'(fwd_sel), 32'h2);
    ex_rs = {5'd5, 5'd0};
    #1 check("fwd_src1_wb_src0_zero", 32'(fwd_sel), 32'h8);
    ex_rs = '0;
    #1 check("fwd_x0", 32'(fwd_sel), 32'h0);
    idle();
    tick();

    // Load-use: two bubbles
    set_lu();
    #1 check("lu_bub1", 32'(ctl), 32'(C_BUB));
    tick();
    idle();
    check("lu_bub2", 32'(ctl), 32'(C_BUB));
    tick();
    check("lu_run", 32'(ctl), 32'(C_RUN));
    check("lu_stall", 32'(stall_cnt), 2);
    set_lu(); ex_rd = 5'd0; id_rs = '0;
    #1 check("lu_rd0_nobub", 32'(ctl), 32'(C_RUN));
    set_lu(); id_rs_used = 2'b01;
    #1 check("lu_unused_nobub", 32'(ctl), 32'(C_RUN));
    idle();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_stall", 32'(stall_cnt), 0);

    // dcache miss inside a bubble
    set_lu();
    #1 check("dm_bub1", 32'(ctl), 32'(C_BUB));
    tick();
    idle(); mem_dcache_req = 1'b1;
    #1 check("dm_frz1", 32'(ctl), 32'(C_FRZ));
    tick();
    check("dm_frz2", 32'(ctl), 32'(C_FRZ));
    tick();
    dcache_resp = 1'b1; icache_read = 1'b1;
    #1 check("dm_frz3_icache", 32'(ctl), 32'(C_FRZ));
    tick();
    idle();
    #1 check("dm_resume_bub", 32'(ctl), 32'(C_BUB));
    tick();
    check("dm_run", 32'(ctl), 32'(C_RUN));
    check("dm_stall", 32'(stall_cnt), 5);

    // Branch over load-use
    set_lu(); ex_br_taken = 1'b1;
    #1 check("br_flush", 32'(ctl), 32'(C_FLU));
    tick();
    idle();
    #1 check("br_nobub", 32'(ctl), 32'(C_RUN));
    check("br_flush_cnt", 32'(flush_cnt), 1);
    check("br_stall_cnt", 32'(stall_cnt), 5);

    // Counter saturation and clear
    icache_read = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    check("sat_stall", 32'(stall_cnt), 15);
    cnt_clr = 1'b1;
    tick();
    check("clr_frz_stall", 32'(stall_cnt), 0);
    check("clr_frz_flush", 32'(flush_cnt), 0);
    cnt_clr = 1'b0;
    tick();
    check("post_clr_stall", 32'(stall_cnt), 1);

    // Reset mid-bubble
    idle();
    set_lu();
    tick();
    idle();
    rst = 1'b0;
    #1 check("rstmid_ctl", 32'(ctl), 32'(C_RST));
    check("rstmid_stall", 32'(stall_cnt), 0);
    tick();
    rst = 1'b1;
    #1 check("rstmid_release", 32'(ctl), 32'(C_RUN));
    tick();
    check("rstmid_noresidual", 32'(ctl), 32'(C_RUN));
    check("rstmid_stall_after", 32'(stall_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
